bus_arbiter: RTL and testbench

Sequencing and arbitration controller for the two-source, two-destination byte bus. It accepts byte transfer requests from two requesters, grants the bus to one at a time, and drives the bus select lines. It holds the granted byte on the chosen destination with a valid/ready handshake and counts completed transfers. It sits between the requesting units and the bus switch fabric, and is the only driver of the bus `sel` lines.

---
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-source, two-destination byte bus arbiter with valid/ready hold stage and transfer counter.
// Define BUS_ARB_RR_EN for round-robin contention; otherwise requester 1 has fixed priority.
module bus_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic       dst1,
    input  logic       dst2,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       rdy_z1,
    input  logic       rdy_z2,
    output logic       gnt1,
    output logic       gnt2,
    output logic [1:0] sel,
    output logic [7:0] z1,
    output logic [7:0] z2,
    output logic       vld_z1,
    output logic       vld_z2,
    output logic [7:0] xfer_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hdst_q, hdst_d;
    logic       hsrc_q, hsrc_d;
    logic [7:0] cnt_q, cnt_d;
`ifdef BUS_ARB_RR_EN
    // 1 = source 1 won last; resets to source 2 so requester 1 wins first.
    logic       last_q, last_d;
`endif

    logic rdy_sel;
    logic acc;
    logic pick1;
    logic win1;
    logic win2;

    always_comb begin
        rdy_sel = hdst_q ? rdy_z1 : rdy_z2;
        acc     = (state_q == IDLE) || ((state_q == BUSY) && rdy_sel);
`ifdef BUS_ARB_RR_EN
        pick1   = !last_q;
`else
        pick1   = 1'b1;
`endif
        win1    = req1 && (!req2 || pick1);
        win2    = req2 && !win1;
        gnt1    = !rst && acc && win1;
        gnt2    = !rst && acc && win2;

        state_d = state_q;
        hold_d  = hold_q;
        hdst_d  = hdst_q;
        hsrc_d  = hsrc_q;
        cnt_d   = cnt_q;
`ifdef BUS_ARB_RR_EN
        last_d  = last_q;
`endif

        if ((state_q == BUSY) && rdy_sel) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = IDLE;
        end

        // A capture in the completion cycle overrides the return to IDLE.
        if (gnt1 || gnt2) begin
            hold_d  = gnt1 ? data1 : data2;
            hdst_d  = gnt1 ? dst1 : dst2;
            hsrc_d  = gnt1;
            state_d = BUSY;
`ifdef BUS_ARB_RR_EN
            last_d  = gnt1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            hdst_q  <= 1'b0;
            hsrc_q  <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef BUS_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hdst_q  <= hdst_d;
            hsrc_q  <= hsrc_d;
            cnt_q   <= cnt_d;
`ifdef BUS_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // sel only changes on capture, so it naturally holds its last value in IDLE.
    assign sel      = {hdst_q, hsrc_q};
    assign vld_z1   = (state_q == BUSY) && hdst_q;
    assign vld_z2   = (state_q == BUSY) && !hdst_q;
    assign z1       = vld_z1 ? hold_q : 8'd0;
    assign z2       = vld_z2 ? hold_q : 8'd0;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter, plus contention and counter-wrap sequences.
module tb_bus_arbiter;

    typedef struct packed {
        logic       rst;
        logic       req1;
        logic       dst1;
        logic [7:0] data1;
        logic       req2;
        logic       dst2;
        logic [7:0] data2;
        logic       rdy1;
        logic       rdy2;
    } in_t;

    typedef struct packed {
        logic       gnt1;
        logic       gnt2;
        logic [1:0] sel;
        logic       vld1;
        logic [7:0] z1;
        logic       vld2;
        logic [7:0] z2;
        logic [7:0] cnt;
    } out_t;

    typedef struct {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, req1, req2, dst1, dst2, rdy_z1, rdy_z2;
    logic [7:0] data1, data2;
    logic       gnt1, gnt2, vld_z1, vld_z2;
    logic [1:0] sel;
    logic [7:0] z1, z2, xfer_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    vec_t vecs[14];

    bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req1     (req1),
        .req2     (req2),
        .dst1     (dst1),
        .dst2     (dst2),
        .data1    (data1),
        .data2    (data2),
        .rdy_z1   (rdy_z1),
        .rdy_z2   (rdy_z2),
        .gnt1     (gnt1),
        .gnt2     (gnt2),
        .sel      (sel),
        .z1       (z1),
        .z2       (z2),
        .vld_z1   (vld_z1),
        .vld_z2   (vld_z2),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mkIn(logic r, logic q1, logic d1, logic [7:0] x1,
                                 logic q2, logic d2, logic [7:0] x2, logic y1, logic y2);
        in_t v;
        v.rst = r;   v.req1 = q1; v.dst1 = d1; v.data1 = x1;
        v.req2 = q2; v.dst2 = d2; v.data2 = x2; v.rdy1 = y1; v.rdy2 = y2;
        return v;
    endfunction

    function automatic out_t mkOut(logic g1, logic g2, logic [1:0] s, logic v1, logic [7:0] a,
                                   logic v2, logic [7:0] b, logic [7:0] c);
        out_t o;
        o.gnt1 = g1; o.gnt2 = g2; o.sel = s; o.vld1 = v1; o.z1 = a;
        o.vld2 = v2; o.z2 = b; o.cnt = c;
        return o;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input in_t s);
        @(negedge clk);
        rst = s.rst;   req1 = s.req1; dst1 = s.dst1; data1 = s.data1;
        req2 = s.req2; dst2 = s.dst2; data2 = s.data2;
        rdy_z1 = s.rdy1; rdy_z2 = s.rdy2;
        #1;
    endtask

    task automatic checkOutput(input out_t e, input string name);
        out_t a;
        a = mkOut(gnt1, gnt2, sel, vld_z1, z1, vld_z2, z2, xfer_cnt);
        testsRun++;
        if (a !== e) begin
            testsFailed++;
            $display("[TB] FAIL %s: got gnt=%b%b sel=%b vld=%b%b z1=%h z2=%h cnt=%0d, expected gnt=%b%b sel=%b vld=%b%b z1=%h z2=%h cnt=%0d",
                     name, a.gnt1, a.gnt2, a.sel, a.vld1, a.vld2, a.z1, a.z2, a.cnt,
                     e.gnt1, e.gnt2, e.sel, e.vld1, e.vld2, e.z1, e.z2, e.cnt);
        end
    endtask

    // Expected BUSY outputs while the contention sequence's previous winner is on the bus.
    function automatic out_t busyOut(logic g1, logic g2, logic prevWas1, logic [7:0] c);
        if (prevWas1) return mkOut(g1, g2, 2'b11, 1'b1, 8'h11, 1'b0, 8'h00, c);
        else          return mkOut(g1, g2, 2'b00, 1'b0, 8'h00, 1'b1, 8'h22, c);
    endfunction

    initial begin
        logic prevWas1;
        logic expG1;
        logic [7:0] expCnt;

        vecs[0]  = '{mkIn(1,1,1,8'hA5,0,0,8'h00,0,0), mkOut(0,0,2'b00,0,8'h00,0,8'h00,8'd0)};
        vecs[1]  = '{mkIn(0,1,1,8'hA5,0,0,8'h00,1,0), mkOut(1,0,2'b00,0,8'h00,0,8'h00,8'd0)};
        vecs[2]  = '{mkIn(0,0,0,8'h00,0,0,8'h00,1,0), mkOut(0,0,2'b11,1,8'hA5,0,8'h00,8'd0)};
        vecs[3]  = '{mkIn(0,0,0,8'h00,0,0,8'h00,0,0), mkOut(0,0,2'b11,0,8'h00,0,8'h00,8'd1)};
        vecs[4]  = '{mkIn(0,0,0,8'h00,1,1,8'h3C,0,0), mkOut(0,1,2'b11,0,8'h00,0,8'h00,8'd1)};
        vecs[5]  = '{mkIn(0,1,0,8'h55,0,0,8'h00,0,1), mkOut(0,0,2'b10,1,8'h3C,0,8'h00,8'd1)};
        vecs[6]  = '{mkIn(0,1,0,8'h55,0,0,8'h00,0,0), mkOut(0,0,2'b10,1,8'h3C,0,8'h00,8'd1)};
        vecs[7]  = '{mkIn(0,1,0,8'h55,0,0,8'h00,0,1), mkOut(0,0,2'b10,1,8'h3C,0,8'h00,8'd1)};
        vecs[8]  = '{mkIn(0,1,0,8'h55,0,0,8'h00,0,0), mkOut(0,0,2'b10,1,8'h3C,0,8'h00,8'd1)};
        vecs[9]  = '{mkIn(0,1,0,8'h55,0,0,8'h00,1,0), mkOut(1,0,2'b10,1,8'h3C,0,8'h00,8'd1)};
        vecs[10] = '{mkIn(0,0,0,8'h00,0,0,8'h00,1,0), mkOut(0,0,2'b01,0,8'h00,1,8'h55,8'd2)};
        vecs[11] = '{mkIn(1,1,1,8'h77,0,0,8'h00,0,1), mkOut(0,0,2'b01,0,8'h00,1,8'h55,8'd2)};
        vecs[12] = '{mkIn(0,0,0,8'h00,0,0,8'h00,0,1), mkOut(0,0,2'b00,0,8'h00,0,8'h00,8'd0)};
        vecs[13] = '{mkIn(0,0,0,8'h00,0,0,8'h00,1,1), mkOut(0,0,2'b00,0,8'h00,0,8'h00,8'd0)};

        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; dst1 = 1'b0; dst2 = 1'b0;
        data1 = 8'h00; data2 = 8'h00; rdy_z1 = 1'b0; rdy_z2 = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Both request every cycle with both destinations ready; runs past 256 transfers.
        for (int k = 0; k < 260; k++) begin
            applyStimulus(mkIn(0,1,1,8'h11,1,0,8'h22,1,1));
`ifdef BUS_ARB_RR_EN
            expG1    = (k % 2 == 0);
            prevWas1 = ((k - 1) % 2 == 0);
`else
            expG1    = 1'b1;
            prevWas1 = 1'b1;
`endif
            expCnt = 8'((k - 1) % 256);
            if (k == 0)
                checkOutput(mkOut(1,0,2'b00,0,8'h00,0,8'h00,8'd0), "contend0");
            else
                checkOutput(busyOut(expG1, !expG1, prevWas1, expCnt), $sformatf("contend%0d", k));
        end

`ifdef BUS_ARB_RR_EN
        prevWas1 = 1'b0;
`else
        prevWas1 = 1'b1;
`endif
        applyStimulus(mkIn(0,0,0,8'h00,0,0,8'h00,1,1));
        checkOutput(busyOut(1'b0, 1'b0, prevWas1, 8'd3), "drain");
        applyStimulus(mkIn(0,0,0,8'h00,0,0,8'h00,1,1));
        checkOutput(mkOut(0,0,prevWas1 ? 2'b11 : 2'b00,0,8'h00,0,8'h00,8'd4), "idleAfterWrap");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
